// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the RC-servo pulse receiver.
//  - Default timing constants, expressed in measurement ticks or clk_12MHz cycles.
//  - rx_state_t: pulse receiver FSM states.
//  - pwm_width_t: 8-bit width value (0 = 1 ms, 255 = 2 ms).
//  - clamp_width(): converts a pulse length in ticks to the 8-bit width scale.
package pwm_pkg;

  localparam int TICK_DIV_DEF      = 47;
  localparam int OFFSET_TICKS_DEF  = 255;
  localparam int MIN_TICKS_DEF     = 230;
  localparam int MAX_TICKS_DEF     = 560;
  localparam int TIMEOUT_TICKS_DEF = 25500;

  typedef logic [7:0] pwm_width_t;

  localparam pwm_width_t FAILSAFE_DEF = 8'd127;

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_RISE,
    HIGH
  } rx_state_t;

  // The subtraction is done in 11-bit signed arithmetic so that pulses shorter
  // than the offset go negative and clamp to 0 instead of wrapping around.
  function automatic pwm_width_t clamp_width(input logic [9:0] ticks,
                                             input logic [9:0] offset);
    logic signed [10:0] diff;
    diff = $signed({1'b0, ticks}) - $signed({1'b0, offset});
    if (diff[10]) begin
      return 8'd0;
    end else if (diff > 11'sd255) begin
      return 8'd255;
    end else begin
      return diff[7:0];
    end
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: clock-enable prescaler for the pulse measurement.
//  Counts 0..TICK_DIV-1 and raises tick for one cycle at TICK_DIV-1.
//  A restart forces the count back to 0 and suppresses that cycle's tick, so
//  the first tick after a restart lands exactly TICK_DIV cycles later.
// Ports:
//  clk_12MHz  in   system clock
//  reset      in   asynchronous, active-low reset
//  restart    in   synchronous restart of the prescaler
//  tick       out  one-cycle enable every TICK_DIV cycles
module pwm_tick_gen
  import pwm_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk_12MHz,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q + CW'(1);
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end
  end

  always_ff @(posedge clk_12MHz or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_receiver.sv
// pwm_receiver: measures RC-servo pulses and converts them to an 8-bit width.
//  1 ms -> 0, 2 ms -> 255. Malformed pulses are rejected, and a loss of signal
//  drives the failsafe width and raises signal_lost.
// Ports:
//  clk_12MHz    in   system clock
//  reset        in   asynchronous, active-low reset
//  pwm_in       in   raw pulse input, asynchronous to clk_12MHz
//  width        out  last accepted pulse width, 0..255
//  valid        out  one-cycle strobe when width is updated from a pulse
//  signal_lost  out  1 = no accepted pulse within TIMEOUT_TICKS
module pwm_receiver
  import pwm_pkg::*;
#(
  parameter int         TICK_DIV      = TICK_DIV_DEF,
  parameter int         OFFSET_TICKS  = OFFSET_TICKS_DEF,
  parameter int         MIN_TICKS     = MIN_TICKS_DEF,
  parameter int         MAX_TICKS     = MAX_TICKS_DEF,
  parameter int         TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter pwm_width_t FAILSAFE      = FAILSAFE_DEF
) (
  input  logic       clk_12MHz,
  input  logic       reset,
  input  logic       pwm_in,
  output logic [7:0] width,
  output logic       valid,
  output logic       signal_lost
);

  localparam logic [9:0]  MIN_T     = 10'(MIN_TICKS);
  localparam logic [9:0]  MAX_T     = 10'(MAX_TICKS);
  localparam logic [9:0]  OFFSET_T  = 10'(OFFSET_TICKS);
  localparam logic [9:0]  PULSE_SAT = 10'h3FF;
  localparam logic [14:0] TIMEOUT_T = 15'(TIMEOUT_TICKS);

  // sync_q[1] is the synchronized input; sync_q[2] is its previous value.
  logic [2:0]  sync_q, sync_d;
  logic        rise_q, rise_d;
  logic        fall_q, fall_d;
  logic [1:0]  prime_q, prime_d;
  rx_state_t   state_q, state_d;
  logic [9:0]  pulse_q, pulse_d;
  logic [14:0] timeout_q, timeout_d;
  pwm_width_t  width_q, width_d;
  logic        valid_q, valid_d;
  logic        lost_q, lost_d;

  logic       tick;
  logic       primed;
  logic       accept;
  logic [9:0] pulse_inc;

  pwm_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_12MHz (clk_12MHz),
    .reset     (reset),
    .restart   (rise_q),
    .tick      (tick)
  );

  // The synchronizer is cleared by reset, so for the first few cycles it shows
  // 0 regardless of the pin. primed holds the FSM in WAIT_LOW until the
  // pipeline reflects the real pin, so a pulse already in progress at reset
  // release is not mistaken for a low level followed by a fresh rising edge.
  always_comb begin
    sync_d  = {sync_q[1:0], pwm_in};
    rise_d  = sync_q[1] & ~sync_q[2];
    fall_d  = ~sync_q[1] & sync_q[2];
    primed  = (prime_q == 2'd3);
    prime_d = primed ? prime_q : prime_q + 2'd1;
  end

  // The tick arriving in the same cycle as the falling edge is still counted,
  // which makes the measured length floor(high_clks / TICK_DIV) exactly.
  always_comb begin
    state_d   = state_q;
    pulse_d   = pulse_q;
    accept    = 1'b0;
    pulse_inc = (tick && (pulse_q != PULSE_SAT)) ? pulse_q + 10'd1 : pulse_q;
    case (state_q)
      WAIT_LOW: begin
        if (primed && !sync_q[1]) begin
          state_d = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (rise_q) begin
          pulse_d = '0;
          state_d = HIGH;
        end
      end
      HIGH: begin
        pulse_d = pulse_inc;
        if (fall_q) begin
          state_d = WAIT_RISE;
          accept  = (pulse_inc >= MIN_T) && (pulse_inc <= MAX_T);
        end else if (pulse_inc > MAX_T) begin
          state_d = WAIT_LOW;
        end
      end
      default: begin
        state_d = WAIT_LOW;
      end
    endcase
  end

  // An accept takes priority over the timeout firing in the same cycle.
  always_comb begin
    width_d   = width_q;
    valid_d   = 1'b0;
    lost_d    = lost_q;
    timeout_d = timeout_q;
    if (accept) begin
      width_d   = clamp_width(pulse_inc, OFFSET_T);
      valid_d   = 1'b1;
      lost_d    = 1'b0;
      timeout_d = '0;
    end else if (tick && (timeout_q != TIMEOUT_T)) begin
      timeout_d = timeout_q + 15'd1;
      if ((timeout_q + 15'd1) == TIMEOUT_T) begin
        lost_d  = 1'b1;
        width_d = FAILSAFE;
      end
    end
  end

  always_ff @(posedge clk_12MHz or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      prime_q   <= '0;
      state_q   <= WAIT_LOW;
      pulse_q   <= '0;
      timeout_q <= '0;
      width_q   <= FAILSAFE;
      valid_q   <= 1'b0;
      lost_q    <= 1'b1;
    end else begin
      sync_q    <= sync_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      prime_q   <= prime_d;
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      timeout_q <= timeout_d;
      width_q   <= width_d;
      valid_q   <= valid_d;
      lost_q    <= lost_d;
    end
  end

  assign width       = width_q;
  assign valid       = valid_q;
  assign signal_lost = lost_q;

endmodule

// File: tb/tb_pwm_receiver.sv
// tb_pwm_receiver: self-checking bench for pwm_receiver.
//  The prescaler and timeout are shortened so that a full run stays short;
//  pulse lengths are written as ticks * TICK_DIV (+ remainder) clock cycles.
module tb_pwm_receiver;

  localparam int TICK_DIV = 4;
  localparam int TIMEOUT  = 2000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pwm_in;
  logic [7:0] width;
  logic       valid;
  logic       lost;

  typedef struct {
    int         high_clks;
    bit         accept;
    logic [7:0] exp_width;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic [7:0] last_width;
  int         checks = 0;
  int         passes = 0;
  int         valid_seen = 0;

  always #5 clk = ~clk;

  pwm_receiver #(
    .TICK_DIV      (TICK_DIV),
    .TIMEOUT_TICKS (TIMEOUT)
  ) dut (
    .clk_12MHz   (clk),
    .reset       (rst_n),
    .pwm_in      (pwm_in),
    .width       (width),
    .valid       (valid),
    .signal_lost (lost)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one high pulse of high_clks sampled cycles, then low_clks of low.
  task automatic applyStimulus(input int high_clks, input int low_clks);
    @(posedge clk);
    #1 pwm_in = 1'b1;
    repeat (high_clks) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (low_clks) @(posedge clk);
  endtask

  // Scoreboard: every valid strobe must match the oldest expected width.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_valid: got width %0d, expected no strobe", width);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("width_on_valid", int'(width), int'(mon_exp));
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got no completion, expected finish in time");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs.push_back('{383*4,     1'b1, 8'd128});
    vecs.push_back('{255*4,     1'b1, 8'd0});
    vecs.push_back('{510*4,     1'b1, 8'd255});
    vecs.push_back('{100*4,     1'b0, 8'd0});
    vecs.push_back('{240*4,     1'b1, 8'd0});
    vecs.push_back('{540*4,     1'b1, 8'd255});
    vecs.push_back('{230*4,     1'b1, 8'd0});
    vecs.push_back('{229*4 + 3, 1'b0, 8'd0});
    vecs.push_back('{560*4 + 3, 1'b1, 8'd255});
    vecs.push_back('{561*4,     1'b0, 8'd0});
    vecs.push_back('{300*4 + 3, 1'b1, 8'd45});
    vecs.push_back('{700*4,     1'b0, 8'd0});
    vecs.push_back('{256*4,     1'b1, 8'd1});
    vecs.push_back('{383*4 + 3, 1'b1, 8'd128});

    // Reset state and idle input.
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_width", int'(width), 127);
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_lost", int'(lost), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_valid_count", valid_seen, 0);
    checkOutput("idle_width", int'(width), 127);
    checkOutput("idle_lost", int'(lost), 1);

    // Table of single pulses.
    last_width = 8'd127;
    for (int i = 0; i < vecs.size(); i++) begin
      valid_seen = 0;
      if (vecs[i].accept) begin
        exp_q.push_back(vecs[i].exp_width);
        last_width = vecs[i].exp_width;
      end
      applyStimulus(vecs[i].high_clks, 60);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_valid_count", i), valid_seen, int'(vecs[i].accept));
      checkOutput($sformatf("vec%0d_width", i), int'(width), int'(last_width));
      checkOutput($sformatf("vec%0d_pending", i), exp_q.size(), 0);
      checkOutput($sformatf("vec%0d_lost", i), int'(lost), 0);
    end

    // Back-to-back pulses separated by a single low cycle.
    valid_seen = 0;
    exp_q.push_back(8'd128);
    exp_q.push_back(8'd255);
    applyStimulus(383*4, 0);
    applyStimulus(510*4, 60);
    @(negedge clk);
    checkOutput("b2b_valid_count", valid_seen, 2);
    checkOutput("b2b_width", int'(width), 255);

    // Loss of signal after an accepted pulse, then recovery.
    valid_seen = 0;
    repeat ((TIMEOUT - 50) * TICK_DIV) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_timeout_lost", int'(lost), 0);
    checkOutput("pre_timeout_width", int'(width), 255);
    repeat (60 * TICK_DIV) @(posedge clk);
    @(negedge clk);
    checkOutput("timeout_lost", int'(lost), 1);
    checkOutput("timeout_width", int'(width), 127);
    checkOutput("timeout_valid_count", valid_seen, 0);
    exp_q.push_back(8'd128);
    applyStimulus(383*4, 60);
    @(negedge clk);
    checkOutput("recover_valid_count", valid_seen, 1);
    checkOutput("recover_width", int'(width), 128);
    checkOutput("recover_lost", int'(lost), 0);

    // Reset in the middle of a pulse, released while the pin is still high.
    valid_seen = 0;
    @(posedge clk);
    #1 pwm_in = 1'b1;
    repeat (400) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (300*4) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_valid_count", valid_seen, 0);
    checkOutput("midreset_width", int'(width), 127);
    checkOutput("midreset_lost", int'(lost), 1);
    exp_q.push_back(8'd255);
    applyStimulus(510*4, 60);
    @(negedge clk);
    checkOutput("post_reset_valid_count", valid_seen, 1);
    checkOutput("post_reset_width", int'(width), 255);
    checkOutput("post_reset_lost", int'(lost), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
